// File: rtl/collatz_orbit_checker.sv
// collatz_orbit_checker: predicts a collatz orbit from the seed and checks each emitted element against it
module collatz_orbit_checker #(
  parameter int ARM_TO = 16,
  parameter int STALL_TO = 64,
  parameter int STEP_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       co,
  input  logic              st,
  input  logic [15:0]       x,
  input  logic              bs,
  output logic              done,
  output logic              pass,
  output logic [2:0]        err_code,
  output logic [STEP_W-1:0] steps,
  output logic [19:0]       peak
);
  typedef enum logic [1:0] {IDLE, ARM, TRACK, DONE} state_t;
  state_t state;
  logic [19:0] exp_v;
  logic [15:0] last;
  logic [15:0] cnt;
  logic [21:0] nxt;
  // next predicted orbit value, wide enough to expose 20-bit overflow
  always_comb nxt = exp_v[0] ? {2'b0, exp_v} + {1'b0, exp_v, 1'b0} + 22'd1 : {3'b0, exp_v[19:1]};
  // check sequencer; every error or orbit end lands in DONE for a one-cycle done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      pass <= 1'b0;
      err_code <= 3'd0;
      steps <= '0;
      peak <= '0;
      exp_v <= '0;
      last <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (st) begin
            exp_v <= {4'b0, co};
            last <= co;
            peak <= {4'b0, co};
            steps <= '0;
            pass <= 1'b0;
            cnt <= '0;
            err_code <= co == 16'd0 ? 3'd6 : 3'd0;
            done <= co == 16'd0;
            state <= co == 16'd0 ? DONE : ARM;
          end else begin
            state <= IDLE;
          end
        end
        ARM: begin
          if (bs) begin
            cnt <= '0;
            state <= TRACK;
          end else if (cnt == 16'(ARM_TO - 1)) begin
            err_code <= 3'd3;
            done <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        TRACK: begin
          if (!bs) begin
            pass <= exp_v == 20'd1;
            err_code <= exp_v == 20'd1 ? 3'd0 : 3'd2;
            done <= 1'b1;
            state <= DONE;
          end else if (x != last) begin
            if (nxt[21:20] != 2'b0) begin
              err_code <= 3'd5;
              done <= 1'b1;
              state <= DONE;
            end else if (x != nxt[15:0]) begin
              err_code <= 3'd1;
              done <= 1'b1;
              state <= DONE;
            end else begin
              exp_v <= nxt[19:0];
              last <= x;
              steps <= &steps ? steps : steps + 1'b1;
              peak <= nxt[19:0] > peak ? nxt[19:0] : peak;
              cnt <= '0;
            end
          end else if (cnt == 16'(STALL_TO - 1)) begin
            err_code <= 3'd4;
            done <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_collatz_orbit_checker.sv
// tb_collatz_orbit_checker: table-driven orbit checks plus directed timeout, stall, reset and re-arm sequences
module tb_collatz_orbit_checker;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] co;
  logic st;
  logic [15:0] x;
  logic bs;
  logic done;
  logic pass;
  logic [2:0] err_code;
  logic [9:0] steps;
  logic [19:0] peak;
  int n_pass = 0;
  int n_total = 0;
  int orb[$];

  typedef struct {
    int seed;
    int bad_idx;
    int bad_val;
    int e_pass;
    int e_err;
    int e_steps;
    int e_peak;
  } vec_t;
  vec_t vecs[6];

  collatz_orbit_checker #(.ARM_TO(16), .STALL_TO(64), .STEP_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .co(co), .st(st), .x(x), .bs(bs),
    .done(done), .pass(pass), .err_code(err_code), .steps(steps), .peak(peak)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, req);
  endtask

  task automatic gen(input int s);
    orb.delete();
    orb.push_back(s);
    while (s != 1) begin
      s = (s % 2 != 0) ? 3 * s + 1 : s / 2;
      orb.push_back(s);
    end
  endtask

  task automatic start(input int s);
    co = 16'(s);
    st = 1'b1;
    tick();
    st = 1'b0;
  endtask

  initial begin
    vecs[0] = '{6, -1, 0, 1, 0, 8, 16};
    vecs[1] = '{27, -1, 0, 1, 0, 111, 9232};
    vecs[2] = '{7, 3, 35, 0, 1, 2, 22};
    vecs[3] = '{7, 1, 23, 0, 1, 0, 7};
    vecs[4] = '{3, -1, 0, 1, 0, 7, 16};
    vecs[5] = '{1, -1, 0, 1, 0, 0, 1};
    rst_n = 1'b0;
    st = 1'b0;
    co = '0;
    x = '0;
    bs = 1'b0;
    tick();
    tick();
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_code, 0);
    chk("rst_steps", steps, 0);
    chk("rst_peak", peak, 0);
    rst_n = 1'b1;
    tick();
    for (int v = 0; v < 6; v++) begin
      gen(vecs[v].seed);
      if (vecs[v].bad_idx >= 0) orb[vecs[v].bad_idx] = vecs[v].bad_val;
      start(vecs[v].seed);
      for (int i = 0; i < orb.size(); i++) begin
        x = 16'(orb[i]);
        bs = 1'b1;
        tick();
        if (i == vecs[v].bad_idx) break;
      end
      if (vecs[v].bad_idx < 0) begin
        bs = 1'b0;
        tick();
      end
      bs = 1'b0;
      chk($sformatf("v%0d_done", v), done, 1);
      chk($sformatf("v%0d_pass", v), pass, vecs[v].e_pass);
      chk($sformatf("v%0d_err", v), err_code, vecs[v].e_err);
      chk($sformatf("v%0d_steps", v), steps, vecs[v].e_steps);
      chk($sformatf("v%0d_peak", v), peak, vecs[v].e_peak);
      tick();
      chk($sformatf("v%0d_done_pulse", v), done, 0);
      chk($sformatf("v%0d_hold_steps", v), steps, vecs[v].e_steps);
    end
    start(5);
    for (int i = 0; i < 15; i++) tick();
    chk("arm_early", done, 0);
    tick();
    chk("arm_done", done, 1);
    chk("arm_err", err_code, 3);
    tick();
    start(0);
    chk("zero_done", done, 1);
    chk("zero_err", err_code, 6);
    chk("zero_pass", pass, 0);
    start(1);
    x = 16'd1;
    bs = 1'b1;
    tick();
    bs = 1'b0;
    tick();
    chk("rearm_done", done, 1);
    chk("rearm_pass", pass, 1);
    chk("rearm_err", err_code, 0);
    tick();
    start(3);
    bs = 1'b1;
    x = 16'd3;
    tick();
    x = 16'd10;
    tick();
    for (int i = 0; i < 63; i++) tick();
    chk("stall_early", done, 0);
    tick();
    chk("stall_done", done, 1);
    chk("stall_err", err_code, 4);
    chk("stall_steps", steps, 1);
    bs = 1'b0;
    tick();
    start(6);
    bs = 1'b1;
    x = 16'd6;
    tick();
    x = 16'd3;
    tick();
    x = 16'd10;
    tick();
    chk("mid_steps", steps, 2);
    rst_n = 1'b0;
    tick();
    bs = 1'b0;
    rst_n = 1'b1;
    chk("mrst_done", done, 0);
    chk("mrst_steps", steps, 0);
    chk("mrst_peak", peak, 0);
    chk("mrst_err", err_code, 0);
    start(1);
    x = 16'd1;
    bs = 1'b1;
    tick();
    bs = 1'b0;
    tick();
    chk("post_done", done, 1);
    chk("post_pass", pass, 1);
    chk("post_steps", steps, 0);
    chk("post_peak", peak, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end
endmodule
